// File: rtl/uart_tx_arbiter_if.sv
// uart_tx_arbiter_if -- byte request bus shared by three UART transmit requesters.
//   req_valid[2:0]  per-requester byte valid (bit i = requester i)
//   req_data[23:0]  per-requester byte, requester i on bits [8i+7:8i]
//   req_last[2:0]   per-requester end-of-packet flag, qualified by req_valid
//   req_ready[2:0]  per-requester one-cycle accept strobe from the arbiter
// master: requester side; slave: arbiter side.
interface uart_tx_arbiter_if;
  logic [2:0]  req_valid;
  logic [23:0] req_data;
  logic [2:0]  req_last;
  logic [2:0]  req_ready;

  modport master (output req_valid, output req_data, output req_last, input req_ready);
  modport slave  (input req_valid, input req_data, input req_last, output req_ready);
endinterface

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter -- round-robin arbiter of three byte requesters onto one
// UART transmit line with packet locking and a lock timeout.
// Ports:
//   clk_12p0  in   sole clock, rising edge
//   rst       in   synchronous active-high reset
//   bus       slave modport of uart_tx_arbiter_if (req_valid/data/last/ready)
//   uart_tx   out  registered serial line, idle high
//   busy      out  high while a frame is on the line or a lock is held
//   grant_id  out  requester currently or last granted
// Parameters: CLKS_PER_BIT (2..65535), LOCK_TIMEOUT (1..65535).
// Optional feature: define UART_TX_PARITY_EN for an even-parity bit (8E1);
// undefined gives 8N1.
module uart_tx_arbiter #(
  parameter int unsigned CLKS_PER_BIT = 104,
  parameter int unsigned LOCK_TIMEOUT = 1250
) (
  input  logic              clk_12p0,
  input  logic              rst,
  uart_tx_arbiter_if.slave  bus,
  output logic              uart_tx,
  output logic              busy,
  output logic [1:0]        grant_id
);

`ifdef UART_TX_PARITY_EN
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, HOLD} state_t;
`else
  typedef enum logic [2:0] {IDLE, START, DATA, STOP, HOLD} state_t;
`endif

  localparam logic [15:0] BIT_END = 16'(CLKS_PER_BIT - 1);
  localparam logic [15:0] TO_END  = 16'(LOCK_TIMEOUT - 1);

  state_t      state, state_n;
  logic [15:0] cnt, cnt_n;
  logic [2:0]  bit_idx, bit_n;
  logic [7:0]  shreg, shreg_n;
  logic        last_q, last_n;
  logic [1:0]  grant_q, grant_n;
  logic [1:0]  rr_ptr, rr_n;
  logic [15:0] to_cnt, to_n;
  logic        tx_q, tx_n;
`ifdef UART_TX_PARITY_EN
  logic        par_q, par_n;
`endif

  logic [2:0]  ready;
  logic        take;
  logic [1:0]  take_idx;
  logic        pick_ok;
  logic [1:0]  pick;
  logic [1:0]  idx;
  logic [7:0]  take_byte;

  function automatic logic [1:0] wrap3(input logic [2:0] v);
    return (v >= 3'd3) ? 2'(v - 3'd3) : v[1:0];
  endfunction

  function automatic logic [7:0] sel_byte(input logic [23:0] d, input logic [1:0] i);
    case (i)
      2'd1:    return d[15:8];
      2'd2:    return d[23:16];
      default: return d[7:0];
    endcase
  endfunction

  always_ff @(posedge clk_12p0) begin
    if (rst) begin
      state   <= IDLE;
      cnt     <= '0;
      bit_idx <= '0;
      shreg   <= '0;
      last_q  <= 1'b0;
      grant_q <= '0;
      rr_ptr  <= '0;
      to_cnt  <= '0;
      tx_q    <= 1'b1;
`ifdef UART_TX_PARITY_EN
      par_q   <= 1'b0;
`endif
    end else begin
      state   <= state_n;
      cnt     <= cnt_n;
      bit_idx <= bit_n;
      shreg   <= shreg_n;
      last_q  <= last_n;
      grant_q <= grant_n;
      rr_ptr  <= rr_n;
      to_cnt  <= to_n;
      tx_q    <= tx_n;
`ifdef UART_TX_PARITY_EN
      par_q   <= par_n;
`endif
    end
  end

  always_comb begin
    state_n   = state;
    cnt_n     = cnt;
    bit_n     = bit_idx;
    shreg_n   = shreg;
    last_n    = last_q;
    grant_n   = grant_q;
    rr_n      = rr_ptr;
    to_n      = to_cnt;
    tx_n      = tx_q;
`ifdef UART_TX_PARITY_EN
    par_n     = par_q;
`endif
    ready     = '0;
    take      = 1'b0;
    take_idx  = grant_q;
    take_byte = '0;
    pick_ok   = 1'b0;
    pick      = rr_ptr;
    idx       = rr_ptr;

    // First valid requester scanning upward from rr_ptr, wrapping at 3.
    for (int unsigned k = 0; k < 3; k++) begin
      idx = wrap3({1'b0, rr_ptr} + 3'(k));
      if (!pick_ok && bus.req_valid[idx]) begin
        pick_ok = 1'b1;
        pick    = idx;
      end
    end

    case (state)
      IDLE: begin
        if (pick_ok) begin
          take     = 1'b1;
          take_idx = pick;
        end
      end
      START: begin
        if (cnt == BIT_END) begin
          state_n = DATA;
          cnt_n   = '0;
          bit_n   = '0;
          tx_n    = shreg[0];
        end else begin
          cnt_n = cnt + 16'd1;
        end
      end
      DATA: begin
        if (cnt == BIT_END) begin
          cnt_n = '0;
          if (bit_idx == 3'd7) begin
`ifdef UART_TX_PARITY_EN
            state_n = PARITY;
            tx_n    = par_q;
`else
            state_n = STOP;
            tx_n    = 1'b1;
`endif
          end else begin
            bit_n   = bit_idx + 3'd1;
            shreg_n = shreg >> 1;
            tx_n    = shreg[1];
          end
        end else begin
          cnt_n = cnt + 16'd1;
        end
      end
`ifdef UART_TX_PARITY_EN
      PARITY: begin
        if (cnt == BIT_END) begin
          state_n = STOP;
          cnt_n   = '0;
          tx_n    = 1'b1;
        end else begin
          cnt_n = cnt + 16'd1;
        end
      end
`endif
      STOP: begin
        if (cnt == BIT_END) begin
          cnt_n   = '0;
          to_n    = '0;
          state_n = last_q ? IDLE : HOLD;
        end else begin
          cnt_n = cnt + 16'd1;
        end
      end
      HOLD: begin
        if (bus.req_valid[grant_q]) begin
          take     = 1'b1;
          take_idx = grant_q;
        end else if (to_cnt == TO_END) begin
          state_n = IDLE;
          rr_n    = wrap3({1'b0, grant_q} + 3'd1);
        end else begin
          to_n = to_cnt + 16'd1;
        end
      end
      default: state_n = IDLE;
    endcase

    // Accept path is shared by IDLE and HOLD; the start bit is launched on
    // the same edge that captures the byte.
    if (take) begin
      take_byte       = sel_byte(bus.req_data, take_idx);
      ready[take_idx] = 1'b1;
      grant_n         = take_idx;
      shreg_n         = take_byte;
      last_n          = bus.req_last[take_idx];
`ifdef UART_TX_PARITY_EN
      par_n           = ^take_byte;
`endif
      state_n         = START;
      cnt_n           = '0;
      to_n            = '0;
      tx_n            = 1'b0;
      if (bus.req_last[take_idx]) rr_n = wrap3({1'b0, take_idx} + 3'd1);
    end
  end

  assign bus.req_ready = rst ? 3'b000 : ready;
  assign uart_tx       = tx_q;
  assign busy          = (state != IDLE);
  assign grant_id      = grant_q;

endmodule

// File: doc/uart_tx_arbiter.md
UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

Interface
REQ-001 Parameter CLKS_PER_BIT, default 104, clk_12p0 cycles per UART bit (115200 baud at 12 MHz); legal range 2..65535.
REQ-002 Parameter LOCK_TIMEOUT, default 1250, idle cycles after which a packet lock is released; legal range 1..65535.
REQ-003 clk_12p0  in  1  sole clock, 12 MHz; all logic on rising edge.
REQ-004 rst  in  1  reset, synchronous, active-high.
REQ-005 req_valid  in  3  per-requester byte valid, bit i = requester i.
REQ-006 req_data  in  24  per-requester byte, requester i on bits [8i+7:8i].
REQ-007 req_last  in  3  per-requester end-of-packet flag, qualified by req_valid.
REQ-008 req_ready  out  3  per-requester one-cycle accept strobe; byte transfers when req_valid[i] and req_ready[i] are both high.
REQ-009 uart_tx  out  1  serial line to the board UART TX pin, idle high.
REQ-010 busy  out  1  high while a frame is on the line or a lock is held.
REQ-011 grant_id  out  2  index of the requester currently granted or last granted.

Function
REQ-012 States: IDLE, START, DATA, PARITY (only with UART_TX_PARITY_EN), STOP, HOLD.
REQ-013 IDLE with any req_valid: grant the first valid requester in round-robin order starting at rr_ptr; assert its req_ready for exactly one cycle, capture req_data and req_last, set grant_id, and enter START.
REQ-014 rr_ptr = (granted index + 1) mod 3, updated only when a packet ends (last byte accepted, or timeout).
REQ-015 Frame: start bit 0, 8 data bits LSB first, optional parity, 1 stop bit 1; each bit lasts exactly CLKS_PER_BIT cycles.
REQ-016 Latency: uart_tx falls on the first rising edge after the accept cycle.
REQ-017 After STOP: if captured last=1, go to IDLE; otherwise go to HOLD with the lock kept on grant_id.
REQ-018 HOLD: only the locked requester is served; if its req_valid is high, accept as in REQ-013 with no idle gap beyond one cycle; other requesters' req_ready stays 0.
REQ-019 HOLD: the timeout counter increments each cycle with no valid from the locked requester; at LOCK_TIMEOUT, release the lock, update rr_ptr, and go to IDLE; the counter clears on each accept.
REQ-020 A requester deasserting req_valid without handshake is legal and never causes a stall.
REQ-021 Simultaneous valid from all requesters with rr_ptr=1 grants 1, then 2, then 0 across successive packets.
REQ-022 req_ready is one-hot or zero in every cycle; at most one accept per frame.
REQ-023 uart_tx is driven from a register, glitch-free; it is high in IDLE and HOLD.
REQ-024 busy = (state != IDLE).

Reset
REQ-025 With rst high at a clock edge: state=IDLE, uart_tx=1, req_ready=0, busy=0, grant_id=0, rr_ptr=0, bit and timeout counters cleared.
REQ-026 Reset mid-frame truncates the frame: uart_tx is 1 from the next cycle, and the in-flight byte and lock are discarded.

Configuration
REQ-027 Macro UART_TX_PARITY_EN defined: an even-parity bit (XOR of the 8 data bits) is inserted between the data bits and the stop bit, for a frame of 11 bit-times.
REQ-028 Macro UART_TX_PARITY_EN undefined: there is no PARITY state and the frame is 10 bit-times (8N1); the interface is unchanged.

Verification
REQ-029 CLKS_PER_BIT=4, requester 0 sends 0xA5 with last=1 -> req_ready[0] pulses once, uart_tx bits 0,1,0,1,0,0,1,0,1,1 with 4 cycles each (plus parity 0 before the stop bit when the macro is defined), then busy=0.
REQ-030 All three requesters send single-byte packets (0x11, 0x22, 0x33) held simultaneously after reset -> frames appear in order 0x11, 0x22, 0x33; grant_id goes 0, 1, 2.
REQ-031 Requester 2 sends the 3-byte packet 0x01, 0x02, 0x03 (last on 0x03) while requester 0 is continuously valid -> all three requester-2 bytes are sent contiguously before any requester-0 byte.
REQ-032 LOCK_TIMEOUT=10, requester 1 sends one byte with last=0 and then goes silent, while requester 0 is valid -> after STOP plus 10 idle cycles the lock is released and requester 0 is granted.
REQ-033 rst asserted during bit 3 of frame 0xFF -> uart_tx=1, busy=0, and req_ready=0 on the next edge; a fresh request after release sends a complete frame.
